// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect control for a classic 5-stage pipeline: picks the PC source,
// freezes/flushes IF/ID, bubbles ID/EX, and counts redirects and load-use stalls.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      ex_inst,
    input  logic             br_taken,
    input  logic             mem_hold,
    output logic [1:0]       pc_sel,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_REDIR   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       id_valid_q, id_valid_d;
    logic       ex_valid_q, ex_valid_d;
    logic [1:0] cnt_inc;

    logic [6:0] id_op, ex_op;
    logic [4:0] ex_rd;
    logic       ex_is_jump, redirect, uses_rs1, uses_rs2, load_use;

    always_comb begin
        id_op      = id_inst[6:0];
        ex_op      = ex_inst[6:0];
        ex_rd      = ex_inst[11:7];
        ex_is_jump = (ex_op == OPC_JAL) || (ex_op == OPC_JALR);
        redirect   = ex_valid_q && (ex_is_jump || ((ex_op == OPC_BRANCH) && br_taken));
        uses_rs1   = !((id_op == OPC_LUI) || (id_op == OPC_AUIPC) || (id_op == OPC_JAL));
        uses_rs2   = (id_op == OPC_OP) || (id_op == OPC_STORE) || (id_op == OPC_BRANCH);
        load_use   = ex_valid_q && id_valid_q && (ex_op == OPC_LOAD) && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (ex_rd == id_inst[19:15])) ||
                      (uses_rs2 && (ex_rd == id_inst[24:20])));
    end

    // One action per cycle, highest priority first; a held pipeline changes no state.
    always_comb begin
        pc_sel      = PC_SEQ;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        state_d     = state_q;
        id_valid_d  = id_valid_q;
        ex_valid_d  = ex_valid_q;
        cnt_inc     = 2'b00;
        if (mem_hold) begin
            pc_sel     = PC_HOLD;
            ifid_write = 1'b0;
        end else if (redirect) begin
            pc_sel      = ex_is_jump ? PC_JUMP : PC_BRANCH;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            id_valid_d  = 1'b0;
            ex_valid_d  = 1'b0;
            state_d     = ST_REDIR;
            cnt_inc[0]  = 1'b1;
        end else if (load_use) begin
            pc_sel      = PC_HOLD;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ex_valid_d  = 1'b0;
            state_d     = ST_LDSTALL;
            cnt_inc[1]  = 1'b1;
        end else begin
            id_valid_d = 1'b1;
            ex_valid_d = id_valid_q;
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            id_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    // Index 0 counts redirects, index 1 counts load-use stalls; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}}))
                    cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign state        = state_q;
    assign redirect_cnt = g_cnt[0].cnt_q;
    assign stall_cnt    = g_cnt[1].cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, 16, width of the event counters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 id_inst  input  32  instruction held in IF/ID.
REQ-005 ex_inst  input  32  instruction held in ID/EX.
REQ-006 br_taken  input  1  branch comparator result for ex_inst; ignored unless ex_inst is BRANCH.
REQ-007 mem_hold  input  1  external freeze request (memory wait).
REQ-008 pc_sel  output  2  PC mux select: 0 PC+4, 1 branch target, 2 jump target, 3 hold PC.
REQ-009 ifid_write  output  1  IF/ID load enable.
REQ-010 ifid_flush  output  1  IF/ID cleared to NOP at next edge.
REQ-011 idex_bubble  output  1  ID/EX loaded with NOP at next edge.
REQ-012 state  output  2  registered FSM state: 0 RUN, 1 LDSTALL, 2 REDIR.
REQ-013 redirect_cnt  output  CNT_W  count of taken redirects.
REQ-014 stall_cnt  output  CNT_W  count of load-use stall cycles.

Function
REQ-015 Opcode field is inst[6:0]: BRANCH 1100011, JAL 1101111, JALR 1100111, LOAD 0000011, LUI 0110111, AUIPC 0010111, OP 0110011, STORE 0100011.
REQ-016 Block SHALL keep internal valid bits id_valid, ex_valid; ex_inst/id_inst are evaluated only when the corresponding bit is 1.
REQ-017 redirect = ex_valid AND (ex opcode JAL or JALR, or BRANCH with br_taken=1).
REQ-018 uses_rs1 = id opcode not LUI/AUIPC/JAL; uses_rs2 = id opcode OP, STORE or BRANCH.
REQ-019 load_use = ex_valid AND id_valid AND ex opcode LOAD AND ex_inst[11:7]!=0 AND ((uses_rs1 AND ex_inst[11:7]==id_inst[19:15]) OR (uses_rs2 AND ex_inst[11:7]==id_inst[24:20])).
REQ-020 Priority per cycle: mem_hold > redirect > load_use > normal; exactly one action applies.
REQ-021 mem_hold: pc_sel=3, ifid_write=0, ifid_flush=0, idex_bubble=0; valid bits, state and counters unchanged.
REQ-022 redirect: pc_sel=2 for JAL/JALR, 1 for BRANCH; ifid_write=1, ifid_flush=1, idex_bubble=1; next id_valid=0, ex_valid=0, state REDIR; redirect_cnt+1.
REQ-023 load_use: pc_sel=3, ifid_write=0, ifid_flush=0, idex_bubble=1; next ex_valid=0, id_valid unchanged, state LDSTALL; stall_cnt+1.
REQ-024 normal: pc_sel=0, ifid_write=1, flush/bubble 0; next id_valid=1, ex_valid=id_valid, state RUN.
REQ-025 pc_sel, ifid_write, ifid_flush, idex_bubble SHALL be combinational from inputs and registers (zero latency); state, valid bits, counters update on rising clk.
REQ-026 Counters SHALL saturate at all-ones, never wrap.
REQ-027 Redirect in same cycle as a load-use match: redirect wins, stall_cnt unchanged.
REQ-028 Consecutive redirects are impossible: after REDIR both valid bits are 0, so the next cycle is normal.
REQ-029 A load-use stall lasts exactly one cycle unless mem_hold intervenes; the following cycle ex_valid=0 so no re-stall.

Reset
REQ-030 rst_n=0 SHALL immediately clear id_valid, ex_valid, counters to 0 and state to RUN, independent of clk, including mid-stall or mid-redirect.
REQ-031 During and after reset until valid bits set, outputs SHALL be pc_sel=0, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-032 First two cycles after reset release perform no hazard or redirect detection (valid bits filling).

Verification
REQ-033 ex_inst=JAL (0x0000006F), ex_valid=1 -> pc_sel=2, ifid_flush=1, idex_bubble=1; next state=2, redirect_cnt=1.
REQ-034 ex_inst=BEQ, br_taken=0 -> pc_sel=0, no flush; br_taken=1 -> pc_sel=1, flush, redirect_cnt increments.
REQ-035 ex_inst=lw x5 (rd=5), id_inst=add x6,x5,x7 -> pc_sel=3, ifid_write=0, idex_bubble=1, state=1 next, stall_cnt=1; following cycle pc_sel=0; ex rd=0 -> no stall.
REQ-036 mem_hold=1 with simultaneous redirect condition -> pc_sel=3, no flush, counters unchanged; release -> redirect taken.
REQ-037 Force redirect_cnt to 0xFFFF via 65535 redirects -> further redirects keep 0xFFFF.
REQ-038 Assert rst_n=0 mid-cycle during LDSTALL -> state=0, counters=0, valid bits=0 before next clk edge.
